// File: rtl/pipe_pkg.sv
// Shared types for the pipeline skid register: occupancy state and width default.
package pipe_pkg;

  localparam int unsigned DATA_W_DEFAULT = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  function automatic logic [1:0] occ_of(input skid_state_t s);
    case (s)
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable; reset and clear both restore RST_VAL.
module pipe_data_reg #(
  parameter int unsigned       DATA_W  = 64,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: out_data is always the main register, skid absorbs
// one extra payload so in_ready never depends combinationally on out_ready.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W  = DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  input  logic              freeze,
  output logic [1:0]        occupancy
);

  skid_state_t       state, state_n;
  logic              in_fire, out_fire;
  logic              main_ld, skid_ld, main_from_skid;
  logic [DATA_W-1:0] main_d, skid_q;

  assign in_ready  = (state != TWO) && !freeze;
  assign out_valid = (state != EMPTY) && !freeze;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign main_d    = main_from_skid ? skid_q : in_data;

  // freeze gates both fire signals, so holding state needs no extra term here
  always_comb begin
    state_n        = state;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          main_ld = 1'b1;
          state_n = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_ld = 1'b1;
        end else if (in_fire) begin
          skid_ld = 1'b1;
          state_n = TWO;
        end else if (out_fire) begin
          state_n = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
          state_n        = ONE;
        end
      end
      default: state_n = EMPTY;
    endcase
    if (flush) begin
      state_n = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      occupancy <= 2'd0;
    end else begin
      state     <= state_n;
      occupancy <= occ_of(state_n);
    end
  end

  pipe_data_reg #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .load (main_ld),
    .d    (main_d),
    .q    (out_data)
  );

  pipe_data_reg #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .load (skid_ld),
    .d    (in_data),
    .q    (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: a FIFO-of-at-most-two reference model
// checked every cycle, plus directed scenarios and a long random run.
module tb_pipe_skid_reg;

  localparam int unsigned       W    = 64;
  localparam logic [W-1:0]      RSTV = 64'hDEAD_BEEF_0000_0001;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready, flush, freeze;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int           checks   = 0;
  int           failures = 0;
  int           out_cnt  = 0;
  int           d0xd_cnt = 0;
  bit           mon_en   = 1'b0;
  logic [W-1:0] exp_q[$];

  pipe_skid_reg #(.DATA_W(W), .RST_VAL(RSTV)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .freeze    (freeze),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: held payloads form a FIFO of depth <= 2; rst/flush empty it.
  always @(negedge clk) begin
    if (mon_en) begin
      automatic int  n     = exp_q.size();
      automatic bit  m_rdy = (n < 2) && !freeze;
      automatic bit  m_vld = (n > 0) && !freeze;
      chk("occupancy", W'(occupancy), W'(n));
      chk("in_ready",  W'(in_ready),  W'(m_rdy));
      chk("out_valid", W'(out_valid), W'(m_vld));
      // output side: compare and pop on each downstream transfer
      if (m_vld && out_ready) begin
        chk("out_data", out_data, exp_q[0]);
        if (out_data === 64'hD) d0xd_cnt++;
        out_cnt++;
      end
      if (rst || flush) begin
        exp_q.delete();
      end else begin
        if (m_vld && out_ready) void'(exp_q.pop_front());
        if (in_valid && m_rdy) exp_q.push_back(in_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush = 1'b0; freeze = 1'b0;
    tick();
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_occ",    W'(occupancy), W'(0));
    chk("reset_ovalid", W'(out_valid), W'(0));
    chk("reset_irdy",   W'(in_ready),  W'(1));
    chk("reset_data",   out_data,      RSTV);
    tick();
    rst = 1'b0;
    tick();

    // streaming 1..8 at full throughput
    base = out_cnt;
    out_ready = 1'b1;
    for (int unsigned i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("stream_count", W'(out_cnt - base), W'(8));

    // fill to two, then drain in order
    out_ready = 1'b0;
    push(64'hA);
    push(64'hB);
    @(negedge clk);
    chk("full_occ",  W'(occupancy), W'(2));
    chk("full_irdy", W'(in_ready),  W'(0));
    tick();
    base = out_cnt;
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("drain_count", W'(out_cnt - base), W'(2));

    // flush beats freeze and discards the concurrent input
    out_ready = 1'b0;
    push(64'h11);
    push(64'h12);
    flush = 1'b1; freeze = 1'b1; in_valid = 1'b1; in_data = 64'hC;
    tick();
    flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_occ",    W'(occupancy), W'(0));
    chk("flush_ovalid", W'(out_valid), W'(0));
    chk("flush_data",   out_data,      RSTV);
    tick();

    // freeze holds a single payload, delivered once afterwards
    push(64'hD);
    d0xd_cnt  = 0;
    freeze    = 1'b1;
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("frz_ovalid", W'(out_valid), W'(0));
      chk("frz_irdy",   W'(in_ready),  W'(0));
      chk("frz_data",   out_data,      64'hD);
      tick();
    end
    freeze = 1'b0;
    tick(); tick(); tick();
    chk("frz_once", W'(d0xd_cnt), W'(1));

    // reset while full
    out_ready = 1'b0;
    push(64'h21);
    push(64'h22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_occ",    W'(occupancy), W'(0));
    chk("rst2_ovalid", W'(out_valid), W'(0));
    chk("rst2_irdy",   W'(in_ready),  W'(1));
    tick();

    // random traffic
    for (int unsigned c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(99) < 70);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(99) < 60);
      freeze    = ($urandom_range(99) < 10);
      flush     = ($urandom_range(999) < 10);
      rst       = ($urandom_range(999) < 2);
      tick();
    end
    in_valid = 1'b0; freeze = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    chk("final_empty", W'(occupancy), W'(0));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the payload width (PC and instruction concatenated).
REQ-002 Parameter RST_VAL, default 0, SHALL set the value loaded into the data registers on reset and flush.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 in_valid  input  1  SHALL indicate that upstream presents a payload.
REQ-006 in_data  input  DATA_W  SHALL carry the upstream payload.
REQ-007 in_ready  output  1  SHALL indicate that the block accepts a payload this cycle.
REQ-008 out_valid  output  1  SHALL indicate that a payload is presented downstream.
REQ-009 out_data  output  DATA_W  SHALL carry the downstream payload.
REQ-010 out_ready  input  1  SHALL indicate that downstream accepts a payload.
REQ-011 flush  input  1  SHALL discard all held and incoming payloads.
REQ-012 freeze  input  1  SHALL stall both sides with all state held.
REQ-013 occupancy  output  2  SHALL report the number of held payloads (0..2).

Function
REQ-014 The block SHALL contain a main register (drives out_data) and a skid register, with states EMPTY, ONE and TWO.
REQ-015 An input transfer (in_fire) SHALL occur when in_valid && in_ready; an output transfer (out_fire) SHALL occur when out_valid && out_ready.
REQ-016 in_ready SHALL equal (state != TWO) && !freeze, with no combinational path from out_ready.
REQ-017 out_valid SHALL equal (state != EMPTY) && !freeze.
REQ-018 out_data SHALL come directly from the main register, with no combinational path from in_data.
REQ-019 In EMPTY, in_fire SHALL load main and move to ONE.
REQ-020 In ONE: in_fire with out_fire SHALL load main and stay in ONE; in_fire alone SHALL load skid and move to TWO; out_fire alone SHALL move to EMPTY.
REQ-021 In TWO, out_fire SHALL copy skid to main and move to ONE; otherwise the state SHALL hold.
REQ-022 Latency from in_fire to out_valid SHALL be 1 cycle; sustained throughput with out_ready=1 SHALL be 1 payload per cycle.
REQ-023 Payload order SHALL be strictly FIFO; no payload SHALL be dropped or duplicated except by flush.
REQ-024 While freeze=1 and flush=0, state, main, skid and occupancy SHALL hold.
REQ-025 flush=1 SHALL force EMPTY and load RST_VAL into main and skid on the next edge.
REQ-026 Any in_fire in a flush cycle SHALL be discarded.
REQ-027 flush SHALL take priority over freeze.
REQ-028 occupancy SHALL equal 0, 1 or 2 for EMPTY, ONE or TWO, registered alongside the state.

Reset
REQ-029 With rst=1 at a clock edge, the block SHALL enter EMPTY with main=skid=RST_VAL.
REQ-030 During and after that reset edge: occupancy=0 and out_valid=0; in_ready=1 unless freeze=1.
REQ-031 rst SHALL take priority over flush and freeze.
REQ-032 rst asserted mid-transfer SHALL discard all held payloads.

Structure
REQ-033 The state enum (EMPTY/ONE/TWO) and the default DATA_W constant SHALL reside in the shared package pipe_pkg.
REQ-034 Sub-module pipe_data_reg (DATA_W-wide register with load enable and synchronous clear to RST_VAL) SHALL be instantiated once for main and once for skid.

Verification
REQ-035 Reset, then in_valid=1 with in_data=0x1 through 0x8 on consecutive cycles and out_ready=1 -> out_data=0x1..0x8 on consecutive cycles, first one cycle after the first in_fire, occupancy=1 throughout.
REQ-036 Push 0xA then 0xB with out_ready=0 -> occupancy=2, in_ready=0; then out_ready=1 -> 0xA, then 0xB, delivered in order.
REQ-037 In TWO, flush=1 together with freeze=1 and in_valid=1 (in_data=0xC) -> next cycle occupancy=0, out_valid=0, out_data=RST_VAL, 0xC never appears at the output.
REQ-038 In ONE holding 0xD, freeze=1 for 3 cycles with out_ready=1 -> out_valid=0, in_ready=0, out_data=0xD held; after freeze=0, 0xD delivered exactly once.
REQ-039 In TWO, rst=1 for one cycle -> occupancy=0, out_valid=0, in_ready=1 on the following cycle.
REQ-040 Random in_valid/out_ready/freeze over 10k cycles against a scoreboard -> zero order, loss or duplication errors, and in_ready never 1 in TWO.
